ibex_irq_ctrl: RTL and testbench

- Interrupt controller between the raw interrupt pins and the core controller.
- Synchronises the irqs_t inputs and the NMI, and holds pending state (level or edge per fast line).
- Masks pending state against mie/mstatus.MIE/privilege/debug and selects one winner by fixed priority.
- Presents the winner to the controller through a req/ack handshake; supplies mip and an NMI-nesting guard to the CSR block.

---
 rtl/ibex_pkg.sv | 68 ++++++
 rtl/ibex_irq_prio.sv | 47 ++++
 rtl/ibex_irq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ibex_irq_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// ---------------------------------------------------------------------------
// ibex_pkg
// Shared types and constants for the interrupt controller slice.
//   priv_lvl_e       : privilege level encoding
//   irqs_t           : packed interrupt vector {software, timer, external, fast[14:0]}
//   exc_cause_e      : 6-bit mcause encoding for the named interrupts
//   irq_ctrl_state_e : request/acknowledge FSM states
// Helper functions translate between causes and irqs_t bit positions.
// ---------------------------------------------------------------------------
package ibex_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_M = 2'b11,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_U = 2'b00
    } priv_lvl_e;

    // The first member is the MSB: software is bit 17, fast[0] is bit 0.
    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    // Fast causes are not enumerated; they are built with fast_cause().
    typedef enum logic [5:0] {
        EXC_CAUSE_IRQ_SOFTWARE_M = {1'b1, 5'd3},
        EXC_CAUSE_IRQ_TIMER_M    = {1'b1, 5'd7},
        EXC_CAUSE_IRQ_EXTERNAL_M = {1'b1, 5'd11},
        EXC_CAUSE_IRQ_NM         = {1'b1, 5'd31}
    } exc_cause_e;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_GAP
    } irq_ctrl_state_e;

    localparam int unsigned CSR_MFIX_BIT_LOW    = 16;
    localparam int unsigned CSR_MFIX_BIT_HIGH   = 30;
    localparam logic [4:0]  IRQ_FAST_CAUSE_BASE = 5'd16;

    function automatic exc_cause_e fast_cause(input logic [3:0] idx);
        return exc_cause_e'({1'b1, IRQ_FAST_CAUSE_BASE + {1'b0, idx}});
    endfunction

    // One-hot irqs_t position of a maskable cause; zero for NMI.
    function automatic irqs_t irq_mask_of_cause(input exc_cause_e cause);
        irqs_t      mask;
        logic [4:0] code;
        mask = '0;
        code = cause[4:0];
        if (cause == EXC_CAUSE_IRQ_SOFTWARE_M) begin
            mask.irq_software = 1'b1;
        end else if (cause == EXC_CAUSE_IRQ_TIMER_M) begin
            mask.irq_timer = 1'b1;
        end else if (cause == EXC_CAUSE_IRQ_EXTERNAL_M) begin
            mask.irq_external = 1'b1;
        end else if (cause[5] && (code >= IRQ_FAST_CAUSE_BASE) &&
                     (code < IRQ_FAST_CAUSE_BASE + 5'd15)) begin
            mask.irq_fast = 15'd1 << (code - IRQ_FAST_CAUSE_BASE);
        end
        return mask;
    endfunction

endpackage

// File: rtl/ibex_irq_prio.sv
// ---------------------------------------------------------------------------
// ibex_irq_prio
// Combinational fixed-priority selector.
//   eligible : irqs_t-format vector of interrupts allowed to be taken
//   nmi      : NMI eligible
//   valid    : at least one candidate present
//   cause    : winning cause (NMI, fast[0]..fast[14], external, software, timer)
// ---------------------------------------------------------------------------
module ibex_irq_prio
    import ibex_pkg::*;
(
    input  logic [17:0] eligible,
    input  logic        nmi,
    output logic        valid,
    output exc_cause_e  cause
);

    irqs_t irqs;
    assign irqs = irqs_t'(eligible);

    always_comb begin
        valid = 1'b0;
        cause = EXC_CAUSE_IRQ_SOFTWARE_M;
        if (nmi) begin
            valid = 1'b1;
            cause = EXC_CAUSE_IRQ_NM;
        end else if (|irqs.irq_fast) begin
            valid = 1'b1;
            // Walk downwards so the lowest-numbered fast line is written last.
            for (int i = 14; i >= 0; i--) begin
                if (irqs.irq_fast[i]) begin
                    cause = fast_cause(4'(i));
                end
            end
        end else if (irqs.irq_external) begin
            valid = 1'b1;
            cause = EXC_CAUSE_IRQ_EXTERNAL_M;
        end else if (irqs.irq_software) begin
            valid = 1'b1;
            cause = EXC_CAUSE_IRQ_SOFTWARE_M;
        end else if (irqs.irq_timer) begin
            valid = 1'b1;
            cause = EXC_CAUSE_IRQ_TIMER_M;
        end
    end

endmodule

// File: rtl/ibex_irq_ctrl.sv
// ---------------------------------------------------------------------------
// ibex_irq_ctrl
// Interrupt controller between the raw pins and the core controller.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   irqs_i, irq_nm_i    : raw interrupt pins (irqs_t format) and NMI pin
//   mie_i, mstatus_mie_i, priv_mode_i, debug_mode_i : masking context
//   mret_i              : MRET retired, leaves NMI mode
//   irq_ack_i           : controller takes the presented interrupt
//   irq_req_o, irq_cause_o : presented request and its cause
//   mip_o               : registered pending view (no NMI)
//   nmi_mode_o          : NMI handler active
// ---------------------------------------------------------------------------
module ibex_irq_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned SyncStages  = 2,
    parameter logic [14:0] FastIrqEdge = 15'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [17:0] irqs_i,
    input  logic        irq_nm_i,
    input  logic [17:0] mie_i,
    input  logic        mstatus_mie_i,
    input  logic [1:0]  priv_mode_i,
    input  logic        debug_mode_i,
    input  logic        mret_i,
    input  logic        irq_ack_i,
    output logic        irq_req_o,
    output logic [5:0]  irq_cause_o,
    output logic [17:0] mip_o,
    output logic        nmi_mode_o
);

    logic [18:0] raw_in;
    logic [18:0] synced;

    assign raw_in = {irq_nm_i, irqs_i};

    // Synchroniser chain; zero stages means the pins are already clk_i-synchronous.
    if (SyncStages == 0) begin : g_no_sync
        assign synced = raw_in;
    end else begin : g_sync
        logic [18:0] sync_q [SyncStages];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < SyncStages; i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                sync_q[0] <= raw_in;
                for (int i = 1; i < SyncStages; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end
        assign synced = sync_q[SyncStages-1];
    end

    irqs_t           sync_irqs;
    logic            sync_nm;
    logic [14:0]     prev_fast_q;
    logic            prev_nm_q;
    logic [14:0]     fast_rise;
    logic            nm_rise;

    irq_ctrl_state_e state_q, state_d;
    exc_cause_e      cause_q, cause_d;
    irqs_t           pending_q, pending_d;
    logic            nmi_latch_q, nmi_latch_d;
    logic            nmi_mode_q;

    irqs_t           cause_mask;
    logic            ack_taken;
    logic            nmi_ack;
    logic [14:0]     fast_clear;

    logic            global_en;
    logic            irq_gate;
    logic [17:0]     eligible;
    logic            nmi_eligible;
    logic            still_eligible;
    logic            win_valid;
    exc_cause_e      win_cause;

    assign sync_irqs = irqs_t'(synced[17:0]);
    assign sync_nm   = synced[18];
    assign fast_rise = sync_irqs.irq_fast & ~prev_fast_q;
    assign nm_rise   = sync_nm & ~prev_nm_q;

    // An ack only counts while a request is actually being presented.
    assign cause_mask = irq_mask_of_cause(cause_q);
    assign ack_taken  = (state_q == IRQ_REQ) && irq_ack_i;
    assign nmi_ack    = ack_taken && (cause_q == EXC_CAUSE_IRQ_NM);
    assign fast_clear = ack_taken ? cause_mask.irq_fast : '0;

    // Level lines follow the synchronised pin; edge lines latch a rising edge
    // and drop on ack, with a same-cycle new edge taking precedence.
    always_comb begin
        pending_d          = sync_irqs;
        pending_d.irq_fast = (sync_irqs.irq_fast & ~FastIrqEdge) |
                             (FastIrqEdge & (fast_rise | (pending_q.irq_fast & ~fast_clear)));
        nmi_latch_d        = nm_rise | (nmi_latch_q & ~nmi_ack);
    end

    assign global_en      = (priv_lvl_e'(priv_mode_i) != PRIV_LVL_M) || mstatus_mie_i;
    assign irq_gate       = global_en && !debug_mode_i && !nmi_mode_q;
    assign eligible       = pending_q & mie_i & {18{irq_gate}};
    assign nmi_eligible   = nmi_latch_q && !debug_mode_i && !nmi_mode_q;
    assign still_eligible = |(eligible & cause_mask);

    ibex_irq_prio u_prio (
        .eligible (eligible),
        .nmi      (nmi_eligible),
        .valid    (win_valid),
        .cause    (win_cause)
    );

    // Request FSM: the cause is frozen in REQ, so later higher-priority
    // arrivals wait for the next IDLE. An NMI is only pulled back by debug entry.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IRQ_IDLE: begin
                if (win_valid) begin
                    state_d = IRQ_REQ;
                    cause_d = win_cause;
                end
            end
            IRQ_REQ: begin
                if (irq_ack_i) begin
                    state_d = IRQ_GAP;
                end else if (cause_q == EXC_CAUSE_IRQ_NM) begin
                    if (debug_mode_i) begin
                        state_d = IRQ_IDLE;
                    end
                end else if (!still_eligible) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_GAP: begin
                state_d = IRQ_IDLE;
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_fast_q <= '0;
            prev_nm_q   <= 1'b0;
            pending_q   <= '0;
            nmi_latch_q <= 1'b0;
            state_q     <= IRQ_IDLE;
            cause_q     <= EXC_CAUSE_IRQ_SOFTWARE_M;
            nmi_mode_q  <= 1'b0;
        end else begin
            prev_fast_q <= sync_irqs.irq_fast;
            prev_nm_q   <= sync_nm;
            pending_q   <= pending_d;
            nmi_latch_q <= nmi_latch_d;
            state_q     <= state_d;
            cause_q     <= cause_d;
            // An NMI ack in the same cycle as MRET re-enters NMI mode.
            if (nmi_ack) begin
                nmi_mode_q <= 1'b1;
            end else if (mret_i) begin
                nmi_mode_q <= 1'b0;
            end
        end
    end

    assign irq_req_o   = (state_q == IRQ_REQ);
    assign irq_cause_o = cause_q;
    assign mip_o       = pending_q;
    assign nmi_mode_o  = nmi_mode_q;

    ack_only_in_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        irq_ack_i |-> (state_q == IRQ_REQ));

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ibex_irq_ctrl
// Self-checking bench for ibex_irq_ctrl (SyncStages=2, fast[5] edge-latched).
// Steady-state vector table, directed multi-cycle sequences, and a random
// phase compared against a history-based reference model.
// ---------------------------------------------------------------------------
module tb_ibex_irq_ctrl;

    localparam int          SW_BIT  = 17;
    localparam int          TM_BIT  = 16;
    localparam int          EX_BIT  = 15;
    localparam logic [14:0] EDGE_EN = 15'h0020;
    localparam logic [17:0] SW = 18'h20000;
    localparam logic [17:0] TM = 18'h10000;
    localparam logic [17:0] EX = 18'h08000;
    localparam logic [17:0] F0 = 18'h00001;
    localparam logic [17:0] F3 = 18'h00008;
    localparam logic [17:0] F5 = 18'h00020;
    localparam logic [17:0] F14 = 18'h04000;
    localparam logic [17:0] ALL = 18'h3FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] irqs;
    logic        irq_nm;
    logic [17:0] mie;
    logic        mstatus_mie;
    logic [1:0]  priv_mode;
    logic        debug_mode;
    logic        mret;
    logic        irq_ack;
    logic        irq_req;
    logic [5:0]  irq_cause;
    logic [17:0] mip;
    logic        nmi_mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_irq_ctrl #(
        .SyncStages  (2),
        .FastIrqEdge (EDGE_EN)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .irqs_i        (irqs),
        .irq_nm_i      (irq_nm),
        .mie_i         (mie),
        .mstatus_mie_i (mstatus_mie),
        .priv_mode_i   (priv_mode),
        .debug_mode_i  (debug_mode),
        .mret_i        (mret),
        .irq_ack_i     (irq_ack),
        .irq_req_o     (irq_req),
        .irq_cause_o   (irq_cause),
        .mip_o         (mip),
        .nmi_mode_o    (nmi_mode)
    );

    // Reference model: pins are kept as a history; the pending level seen at
    // a given edge is the pin value two cycles earlier.
    logic [18:0] hist[$];
    logic [17:0] m_mip;
    logic        m_nmi_latch;
    bit          m_req;
    bit          m_gap;
    bit          m_nmi_mode;
    logic [5:0]  m_cause;

    function automatic void model_reset();
        hist.delete();
        m_mip       = '0;
        m_nmi_latch = 1'b0;
        m_req       = 1'b0;
        m_gap       = 1'b0;
        m_nmi_mode  = 1'b0;
        m_cause     = 6'h23;
    endfunction

    function automatic logic [18:0] in_at(int k);
        if (k < 0 || k >= hist.size()) return '0;
        return hist[k];
    endfunction

    function automatic int bit_of_cause(logic [5:0] c);
        if (c == 6'h23) return SW_BIT;
        if (c == 6'h27) return TM_BIT;
        if (c == 6'h2B) return EX_BIT;
        if (c >= 6'h30 && c <= 6'h3E) return int'(c) - 48;
        return -1;
    endfunction

    function automatic int model_winner(logic [17:0] elig, bit nmi_el);
        if (nmi_el) return 63;
        for (int i = 0; i < 15; i++) if (elig[i]) return 48 + i;
        if (elig[EX_BIT]) return 43;
        if (elig[SW_BIT]) return 35;
        if (elig[TM_BIT]) return 39;
        return -1;
    endfunction

    function automatic void model_step();
        int          t;
        int          b;
        int          w;
        logic [18:0] lvl;
        logic [18:0] old;
        logic [17:0] elig;
        logic [17:0] rise;
        logic [17:0] clr;
        logic [17:0] edge_mask;
        logic [17:0] new_mip;
        logic        new_latch;
        bit          gate;
        bit          nmi_el;
        bit          nmi_acc;
        t = hist.size();
        hist.push_back({irq_nm, irqs});
        lvl       = in_at(t - 2);
        old       = in_at(t - 3);
        gate      = ((priv_mode != 2'b11) || mstatus_mie) && !debug_mode && !m_nmi_mode;
        elig      = gate ? (m_mip & mie) : '0;
        nmi_el    = m_nmi_latch && !debug_mode && !m_nmi_mode;
        nmi_acc   = m_req && irq_ack && (m_cause == 6'h3F);
        b         = bit_of_cause(m_cause);
        clr       = '0;
        if (m_req && irq_ack && b >= 0) clr[b] = 1'b1;
        edge_mask = {3'b000, EDGE_EN};
        rise      = lvl[17:0] & ~old[17:0];
        new_mip   = (lvl[17:0] & ~edge_mask) | (edge_mask & (rise | (m_mip & ~clr)));
        new_latch = (lvl[18] & ~old[18]) | (m_nmi_latch & ~nmi_acc);
        if (m_req) begin
            if (irq_ack) begin
                m_req = 1'b0;
                m_gap = 1'b1;
            end else if (m_cause == 6'h3F) begin
                if (debug_mode) m_req = 1'b0;
            end else if (b < 0 || !elig[b]) begin
                m_req = 1'b0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            w = model_winner(elig, nmi_el);
            if (w >= 0) begin
                m_req   = 1'b1;
                m_cause = 6'(w);
            end
        end
        if (nmi_acc) m_nmi_mode = 1'b1;
        else if (mret) m_nmi_mode = 1'b0;
        m_mip       = new_mip;
        m_nmi_latch = new_latch;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        irqs        = '0;
        irq_nm      = 1'b0;
        mie         = '0;
        mstatus_mie = 1'b0;
        priv_mode   = 2'b11;
        debug_mode  = 1'b0;
        mret        = 1'b0;
        irq_ack     = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [17:0] irqs;
        logic [17:0] mie;
        logic        mstatus;
        logic [1:0]  priv;
        logic        debug;
        logic        exp_req;
        logic [5:0]  exp_cause;
    } vec_t;

    vec_t vecs[11];

    task automatic apply_stimulus(input vec_t v);
        irqs        = v.irqs;
        mie         = v.mie;
        mstatus_mie = v.mstatus;
        priv_mode   = v.priv;
        debug_mode  = v.debug;
    endtask

    task automatic check_model(input string tag);
        check_output({tag, " req"}, 32'(irq_req), 32'(m_req));
        check_output({tag, " cause"}, 32'(irq_cause), 32'(m_cause));
        check_output({tag, " mip"}, 32'(mip), 32'(m_mip));
        check_output({tag, " nmi_mode"}, 32'(nmi_mode), 32'(m_nmi_mode));
    endtask

    initial begin
        vecs[0]  = '{TM,       TM,  1'b1, 2'b11, 1'b0, 1'b1, 6'h27};
        vecs[1]  = '{F3 | EX,  ALL, 1'b1, 2'b11, 1'b0, 1'b1, 6'h33};
        vecs[2]  = '{SW,       SW,  1'b0, 2'b00, 1'b0, 1'b1, 6'h23};
        vecs[3]  = '{SW,       SW,  1'b0, 2'b00, 1'b1, 1'b0, 6'h23};
        vecs[4]  = '{ALL,      '0,  1'b1, 2'b11, 1'b0, 1'b0, 6'h23};
        vecs[5]  = '{SW | TM,  ALL, 1'b1, 2'b11, 1'b0, 1'b1, 6'h23};
        vecs[6]  = '{EX | TM,  ALL, 1'b1, 2'b11, 1'b0, 1'b1, 6'h2B};
        vecs[7]  = '{F14 | EX, ALL, 1'b1, 2'b11, 1'b0, 1'b1, 6'h3E};
        vecs[8]  = '{TM,       TM,  1'b0, 2'b11, 1'b0, 1'b0, 6'h23};
        vecs[9]  = '{F0 | F14, ALL, 1'b1, 2'b11, 1'b0, 1'b1, 6'h30};
        vecs[10] = '{SW | TM,  TM,  1'b1, 2'b11, 1'b0, 1'b1, 6'h27};

        // Reset values
        do_reset();
        check_output("reset req", 32'(irq_req), 32'd0);
        check_output("reset cause", 32'(irq_cause), 32'h23);
        check_output("reset mip", 32'(mip), 32'd0);
        check_output("reset nmi_mode", 32'(nmi_mode), 32'd0);

        // Steady-state vector table
        for (int v = 0; v < 11; v++) begin
            do_reset();
            apply_stimulus(vecs[v]);
            repeat (6) tick();
            check_output($sformatf("vec%0d req", v), 32'(irq_req), 32'(vecs[v].exp_req));
            check_output($sformatf("vec%0d cause", v), 32'(irq_cause), 32'(vecs[v].exp_cause));
            check_output($sformatf("vec%0d mip", v), 32'(mip), 32'(vecs[v].irqs));
        end

        // Timer latency, ack, gap, re-request on held level
        do_reset();
        mie = TM; mstatus_mie = 1'b1; irqs = TM;
        repeat (3) tick();
        check_output("timer early", 32'(irq_req), 32'd0);
        tick();
        check_output("timer req", 32'(irq_req), 32'd1);
        check_output("timer cause", 32'(irq_cause), 32'h27);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_output("timer gap", 32'(irq_req), 32'd0);
        tick();
        check_output("timer idle", 32'(irq_req), 32'd0);
        tick();
        check_output("timer re-req", 32'(irq_req), 32'd1);

        // Priority frozen while presenting
        do_reset();
        mie = ALL; mstatus_mie = 1'b1; irqs = F3 | EX;
        repeat (4) tick();
        check_output("prio cause", 32'(irq_cause), 32'h33);
        irqs = F3 | EX | F0;
        repeat (4) tick();
        check_output("prio frozen", 32'(irq_cause), 32'h33);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        repeat (2) tick();
        check_output("prio next req", 32'(irq_req), 32'd1);
        check_output("prio next cause", 32'(irq_cause), 32'h30);

        // Edge-latched fast[5]
        do_reset();
        mie = F5; mstatus_mie = 1'b1;
        irqs = F5; tick(); irqs = '0;
        repeat (2) tick();
        check_output("edge latched", 32'(mip), 32'(F5));
        tick();
        check_output("edge cause", 32'(irq_cause), 32'h35);
        repeat (3) tick();
        check_output("edge held", 32'(mip), 32'(F5));
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_output("edge cleared", 32'(mip), 32'd0);
        irqs = F5; tick(); irqs = '0;
        repeat (3) tick();
        check_output("edge req2", 32'(irq_req), 32'd1);
        irqs = F5; tick(); irqs = '0;
        tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_output("edge set wins", 32'(mip), 32'(F5));
        repeat (2) tick();
        check_output("edge re-req", 32'(irq_req), 32'd1);

        // NMI nesting guard and MRET
        do_reset();
        irq_nm = 1'b1; tick(); irq_nm = 1'b0;
        repeat (3) tick();
        check_output("nmi req", 32'(irq_req), 32'd1);
        check_output("nmi cause", 32'(irq_cause), 32'h3F);
        check_output("nmi not in mip", 32'(mip), 32'd0);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_output("nmi mode set", 32'(nmi_mode), 32'd1);
        irq_nm = 1'b1; tick(); irq_nm = 1'b0;
        repeat (6) tick();
        check_output("nmi nested blocked", 32'(irq_req), 32'd0);
        mret = 1'b1; tick(); mret = 1'b0;
        check_output("nmi mret clears", 32'(nmi_mode), 32'd0);
        tick();
        check_output("nmi after mret", 32'(irq_req), 32'd1);
        irq_ack = 1'b1; mret = 1'b1; tick(); irq_ack = 1'b0; mret = 1'b0;
        check_output("nmi ack beats mret", 32'(nmi_mode), 32'd1);

        // NMI withdrawn by debug, latch kept
        do_reset();
        irq_nm = 1'b1; tick(); irq_nm = 1'b0;
        repeat (3) tick();
        debug_mode = 1'b1; tick();
        check_output("nmi debug withdraw", 32'(irq_req), 32'd0);
        debug_mode = 1'b0; tick();
        check_output("nmi debug return", 32'(irq_req), 32'd1);

        // Maskable withdraw
        do_reset();
        mie = EX; mstatus_mie = 1'b1; irqs = EX;
        repeat (4) tick();
        check_output("withdraw pre", 32'(irq_req), 32'd1);
        mie = '0; tick();
        check_output("withdraw req", 32'(irq_req), 32'd0);
        check_output("withdraw mip", 32'(mip), 32'(EX));
        repeat (3) tick();
        check_output("withdraw idle", 32'(irq_req), 32'd0);
        mie = EX; tick();
        check_output("withdraw re-enable", 32'(irq_req), 32'd1);

        // Asynchronous reset while presenting
        do_reset();
        mie = TM; mstatus_mie = 1'b1; irqs = TM;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check_output("async reset req", 32'(irq_req), 32'd0);
        check_output("async reset cause", 32'(irq_cause), 32'h23);
        check_output("async reset mip", 32'(mip), 32'd0);

        // Random traffic against the reference model
        do_reset();
        mie = ALL; mstatus_mie = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            int b;
            irq_nm = 1'b0; mret = 1'b0; irq_ack = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, 17);
                irqs[b] = ~irqs[b];
            end
            if ($urandom_range(0, 39) == 0) irq_nm = 1'b1;
            if ($urandom_range(0, 15) == 0) mie = 18'($urandom);
            if ($urandom_range(0, 15) == 0) mstatus_mie = ~mstatus_mie;
            if ($urandom_range(0, 31) == 0) priv_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) debug_mode = ~debug_mode;
            if ($urandom_range(0, 29) == 0) mret = 1'b1;
            if (m_req && irq_req && $urandom_range(0, 1) == 0) irq_ack = 1'b1;
            tick();
            check_model($sformatf("rand%0d", c));
        end
        irq_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
